half_adder_checker: RTL and testbench
=====================================

Name: half_adder_checker

Overview:
- Synthesizable, self-sequencing stimulus/response checker for a 1-bit half adder DUT.
- Drives the four {a,b} input vectors into the DUT in order and waits a programmable settle time. It then samples sum/carry, compares them against a^b and a&b, and reports an error count, a per-vector fail mask and a pass flag.
- Sits beside the adder as its checking end. Used on-board (LEDs) and in simulation, in place of a hand-written stimulus-only bench.

Parameters:
- SETTLE_CYCLES, 2, clock cycles between driving a vector and sampling the DUT outputs; legal range 0..255.
- ERR_W, 3, width of the error counter; saturates at 2^ERR_W-1.

Ports:
- clk  input  1  rising-edge system clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle request to run a full check pass
- a  output  1  DUT operand a, registered
- b  output  1  DUT operand b, registered
- sum  input  1  DUT sum output
- carry  input  1  DUT carry output
- busy  output  1  high while a pass is in progress
- done  output  1  high from end of pass until next accepted start
- pass  output  1  done && err_count==0
- err_count  output  ERR_W  number of mismatching vectors in last pass, saturating
- fail_vec  output  4  bit i set if vector i ({a,b}=i) mismatched
- vec_idx  output  2  index of the vector currently driven

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (rst_n). All state is in flops clocked by clk.
- Reset values:
  - state=IDLE.
  - a=0, b=0, vec_idx=0.
  - busy=0, done=0, pass=0, err_count=0, fail_vec=0.
  - Settle counter=0.
- Reset asserted mid-pass: aborts immediately to the reset values. No partial results are retained.
- FSM states:
  - IDLE: busy=0. start=1 -> APPLY. Clears err_count and fail_vec, and sets vec_idx=0.
  - APPLY (1 cycle): {a,b} <= vec_idx. Loads the settle counter with SETTLE_CYCLES. Goes to SETTLE if SETTLE_CYCLES>0, else to SAMPLE.
  - SETTLE: decrements the counter each cycle. On the cycle it reads 1 -> SAMPLE. Time spent in SETTLE is exactly SETTLE_CYCLES cycles.
  - SAMPLE (1 cycle): compares sum against (a^b) and carry against (a&b).
    - On mismatch: fail_vec[vec_idx]<=1 and err_count increments, saturating.
    - If vec_idx==3 -> DONE; else vec_idx<=vec_idx+1 -> APPLY.
  - DONE: busy=0, done=1, results held stable. start=1 -> clears results and done, sets vec_idx=0 -> APPLY.
- busy=1 in APPLY, SETTLE and SAMPLE; start is ignored while busy.
- start and the last SAMPLE in the same cycle: start is ignored, and the FSM still enters DONE.
- Latency:
  - Each vector takes SETTLE_CYCLES+2 cycles.
  - start accepted at edge N -> done=1 after edge N+4*(SETTLE_CYCLES+2).
  - Default parameters: 16 cycles.
- Drive and hold rules:
  - a and b change only on the APPLY edge and hold through SETTLE and SAMPLE.
  - After DONE they keep the last vector (1,1) until the next start.
- Comparison semantics: any sampled value other than a clean 0/1 (X/Z in simulation) counts as a mismatch.
- pass: combinational from done and err_count; never high while busy.
- err_count overflow: the counter saturates at 2^ERR_W-1, but fail_vec still records each failing vector.

Test Plan:
- Correct DUT, defaults: reset, pulse start -> {a,b} = 00,01,10,11, each held 4 cycles. done=1 exactly 16 cycles after start; err_count=0, fail_vec=0000, pass=1.
- carry stuck-at-0 DUT -> only vector 3 fails: err_count=1, fail_vec=1000, pass=0.
- sum inverted DUT -> all vectors fail: err_count=4, fail_vec=1111. With ERR_W=2, err_count saturates at 3 and fail_vec=1111.
- SETTLE_CYCLES=0 -> each vector lasts 2 cycles, done after 8 cycles; start pulses during busy have no effect on timing or results.
- rst_n low for 1 cycle at vector 2 of a failing run -> all outputs return to 0 immediately (asynchronously). A new start gives fresh results with no residue.
- Back-to-back: start in DONE after a failing pass, with the DUT now correct -> done drops, results clear on the start edge, and the second pass ends with pass=1.

Source files
------------

// File: rtl/half_adder_checker_if.sv
// Bundle between the half-adder checker and its surroundings: run control and
// results on one side, the driven operands and sampled adder outputs on the other.
interface half_adder_checker_if #(
  parameter int ERR_W = 3
);
  logic             start;
  logic             a;
  logic             b;
  logic             sum;
  logic             carry;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_count;
  logic [3:0]       fail_vec;
  logic [1:0]       vec_idx;

  modport master (
    input  start, sum, carry,
    output a, b, busy, done, pass, err_count, fail_vec, vec_idx
  );

  modport slave (
    output start, sum, carry,
    input  a, b, busy, done, pass, err_count, fail_vec, vec_idx
  );
endinterface

// File: rtl/half_adder_checker.sv
// Self-sequencing checker for a 1-bit half adder: drives all four {a,b} vectors,
// waits a settle time, samples sum/carry and accumulates a fail mask and error count.
module half_adder_checker #(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  half_adder_checker_if.master bus
);

  localparam logic [7:0] SETTLE_INIT = 8'(SETTLE_CYCLES);
  localparam bit         HAS_SETTLE  = (SETTLE_CYCLES > 0);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    APPLY  = 3'd1,
    SETTLE = 3'd2,
    SAMPLE = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic             a_q;
  logic             b_q;
  logic [1:0]       vec_idx_q;
  logic [7:0]       cnt_q;
  logic [ERR_W-1:0] err_q;
  logic [3:0]       fail_q;
  logic             busy;
  logic             done;
  logic             accept;
  logic             mism;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Case-equality so that an undriven or X output from the adder is a failure.
  function automatic logic is_mismatch(input logic op_a, input logic op_b,
                                       input logic s, input logic c);
    return !((s === (op_a ^ op_b)) && (c === (op_a & op_b)));
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (bus.start) state_d = APPLY;
      APPLY:      state_d = HAS_SETTLE ? SETTLE : SAMPLE;
      SETTLE:     if (cnt_q == 8'd1) state_d = SAMPLE;
      SAMPLE:     state_d = (vec_idx_q == 2'd3) ? DONE : APPLY;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    busy   = 1'b0;
    done   = 1'b0;
    accept = 1'b0;
    case (state_q)
      IDLE:                  accept = bus.start;
      APPLY, SETTLE, SAMPLE: busy   = 1'b1;
      DONE: begin
        done   = 1'b1;
        accept = bus.start;
      end
      default: ;
    endcase
  end

  assign mism = is_mismatch(a_q, b_q, bus.sum, bus.carry);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= 1'b0;
      b_q       <= 1'b0;
      vec_idx_q <= 2'd0;
      cnt_q     <= 8'd0;
      err_q     <= '0;
      fail_q    <= 4'd0;
    end else begin
      if (accept) begin
        vec_idx_q <= 2'd0;
        err_q     <= '0;
        fail_q    <= 4'd0;
      end
      if (state_q == APPLY) begin
        {a_q, b_q} <= vec_idx_q;
        cnt_q      <= SETTLE_INIT;
      end
      if (state_q == SETTLE) cnt_q <= cnt_q - 8'd1;
      if (state_q == SAMPLE) begin
        if (mism) begin
          fail_q[vec_idx_q] <= 1'b1;
          err_q             <= sat_inc(err_q);
        end
        if (vec_idx_q != 2'd3) vec_idx_q <= vec_idx_q + 2'd1;
      end
    end
  end

  assign bus.a         = a_q;
  assign bus.b         = b_q;
  assign bus.vec_idx   = vec_idx_q;
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.pass      = done && (err_q == '0);
  assign bus.err_count = err_q;
  assign bus.fail_vec  = fail_q;

endmodule

// File: tb/tb_half_adder_checker.sv
// Bench for half_adder_checker: three checker instances with different settle
// times and counter widths, each beside a half-adder model with injectable faults.
module tb_half_adder_checker;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  int sc_of [3] = '{2, 2, 0};
  int ew_of [3] = '{3, 2, 3};

  logic       start   [3];
  logic [3:0] fsum    [3];
  logic [3:0] fcar    [3];
  logic       busy_o  [3];
  logic       done_o  [3];
  logic       pass_o  [3];
  logic [2:0] ec      [3];
  logic [3:0] fv      [3];
  logic [1:0] ab      [3];
  logic [1:0] vi      [3];
  logic [1:0] prev_ab [3];

  half_adder_checker_if #(.ERR_W(3)) bus0 ();
  half_adder_checker_if #(.ERR_W(2)) bus1 ();
  half_adder_checker_if #(.ERR_W(3)) bus2 ();

  half_adder_checker #(.SETTLE_CYCLES(2), .ERR_W(3)) u0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  half_adder_checker #(.SETTLE_CYCLES(2), .ERR_W(2)) u1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  half_adder_checker #(.SETTLE_CYCLES(0), .ERR_W(3)) u2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  // Half adders under test: a fault bit flips that output for that vector.
  assign bus0.start = start[0];
  assign bus0.sum   = bus0.a ^ bus0.b ^ fsum[0][{bus0.a, bus0.b}];
  assign bus0.carry = (bus0.a & bus0.b) ^ fcar[0][{bus0.a, bus0.b}];
  assign bus1.start = start[1];
  assign bus1.sum   = bus1.a ^ bus1.b ^ fsum[1][{bus1.a, bus1.b}];
  assign bus1.carry = (bus1.a & bus1.b) ^ fcar[1][{bus1.a, bus1.b}];
  assign bus2.start = start[2];
  assign bus2.sum   = bus2.a ^ bus2.b ^ fsum[2][{bus2.a, bus2.b}];
  assign bus2.carry = (bus2.a & bus2.b) ^ fcar[2][{bus2.a, bus2.b}];

  assign busy_o[0] = bus0.busy;  assign done_o[0] = bus0.done;  assign pass_o[0] = bus0.pass;
  assign busy_o[1] = bus1.busy;  assign done_o[1] = bus1.done;  assign pass_o[1] = bus1.pass;
  assign busy_o[2] = bus2.busy;  assign done_o[2] = bus2.done;  assign pass_o[2] = bus2.pass;
  assign ec[0] = bus0.err_count; assign ec[1] = {1'b0, bus1.err_count}; assign ec[2] = bus2.err_count;
  assign fv[0] = bus0.fail_vec;  assign fv[1] = bus1.fail_vec;  assign fv[2] = bus2.fail_vec;
  assign ab[0] = {bus0.a, bus0.b}; assign ab[1] = {bus1.a, bus1.b}; assign ab[2] = {bus2.a, bus2.b};
  assign vi[0] = bus0.vec_idx;   assign vi[1] = bus1.vec_idx;   assign vi[2] = bus2.vec_idx;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_zero(input int k, input string pfx);
    chk({pfx, "_busy"}, busy_o[k], 0);
    chk({pfx, "_done"}, done_o[k], 0);
    chk({pfx, "_pass"}, pass_o[k], 0);
    chk({pfx, "_err"},  ec[k], 0);
    chk({pfx, "_fail"}, fv[k], 0);
    chk({pfx, "_ab"},   ab[k], 0);
    chk({pfx, "_vidx"}, vi[k], 0);
  endtask

  // Reference: a pass applies vectors 0..3, each for sc+2 cycles; a vector fails
  // when either output is faulted; the error count is the number of failing
  // vectors clipped to the counter maximum.
  task automatic run_pass(input int k, input bit noise);
    int sc, total, j, exp_err, lim, exp_v;
    bit seen;
    logic [3:0] exp_fail;
    sc       = sc_of[k];
    total    = 4 * (sc + 2);
    exp_fail = fsum[k] | fcar[k];
    exp_err  = $countones(exp_fail);
    lim      = (1 << ew_of[k]) - 1;
    if (exp_err > lim) exp_err = lim;

    @(negedge clk); start[k] = 1'b1;
    @(negedge clk); start[k] = 1'b0;
    chk("acc_busy", busy_o[k], 1);
    chk("acc_done", done_o[k], 0);
    chk("acc_err",  ec[k], 0);
    chk("acc_fail", fv[k], 0);
    chk("acc_ab",   ab[k], prev_ab[k]);
    chk("acc_vidx", vi[k], 0);

    j = 0;
    seen = 1'b0;
    while (!seen && j < total + 8) begin
      if (noise) start[k] = 1'($urandom_range(0, 1));
      @(negedge clk);
      j++;
      if (done_o[k]) seen = 1'b1;
      else begin
        exp_v = (j - 1) / (sc + 2);
        if (exp_v > 3) exp_v = 3;
        chk("run_busy", busy_o[k], 1);
        chk("run_pass", pass_o[k], 0);
        chk("run_ab",   ab[k], exp_v);
      end
    end
    start[k] = 1'b0;
    chk("latency",  j, total);
    chk("end_busy", busy_o[k], 0);
    chk("end_err",  ec[k], exp_err);
    chk("end_fail", fv[k], exp_fail);
    chk("end_pass", pass_o[k], (exp_err == 0));
    chk("end_ab",   ab[k], 3);
    chk("end_vidx", vi[k], 3);
    repeat (3) @(negedge clk);
    chk("hold_done", done_o[k], 1);
    chk("hold_fail", fv[k], exp_fail);
    chk("hold_ab",   ab[k], 3);
    prev_ab[k] = 2'd3;
  endtask

  initial begin
    int j;
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      start[k] = 1'b0; fsum[k] = 4'd0; fcar[k] = 4'd0; prev_ab[k] = 2'd0;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) check_zero(k, "reset");
    rst_n = 1'b1;

    run_pass(0, 1'b0);                       // correct adder
    fcar[0] = 4'b1000;
    run_pass(0, 1'b0);                       // carry stuck-at-0
    fcar[0] = 4'b0000; fsum[0] = 4'b1111;
    run_pass(0, 1'b0);                       // sum inverted
    fsum[0] = 4'b0000;
    run_pass(0, 1'b0);                       // back-to-back, now correct

    fsum[1] = 4'b1111;
    run_pass(1, 1'b0);                       // saturating 2-bit counter
    run_pass(2, 1'b1);                       // zero settle, start noise while busy

    for (int r = 0; r < 9; r++) begin
      int k;
      k = r % 3;
      fsum[k] = 4'($urandom);
      fcar[k] = 4'($urandom);
      run_pass(k, k == 2);
    end

    // Asynchronous reset in the middle of a failing pass.
    fsum[0] = 4'b1111; fcar[0] = 4'b0000;
    @(negedge clk); start[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0;
    j = 0;
    while (vi[0] != 2'd2 && j < 50) begin
      @(negedge clk);
      j++;
    end
    chk("mid_vidx", vi[0], 2);
    chk("mid_err",  ec[0], 2);
    #2 rst_n = 1'b0;
    #1;
    check_zero(0, "arst0");
    check_zero(2, "arst2");
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 3; k++) prev_ab[k] = 2'd0;
    fsum[0] = 4'b0000;
    run_pass(0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
